// File: rtl/decode_stage_pkg.sv
// Shared RV32I opcode constants, ALU operation codes, immediate formats and the decoded bundle.
// The immediate extraction helper lives here so every decode consumer agrees on bit placement.
package decode_stage_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    // Immediate is kept at the native 32 bits; the stage sign-extends to XLEN on output.
    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        alu_op_e     alu_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
        logic        jump;
        logic        alu_src_imm;
        logic        illegal;
    } dec_t;

    function automatic logic [31:0] imm_extract(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
        return imm;
    endfunction

    // Shared by OP and OP-IMM; alt is funct7[5] where it is meaningful for the opcode.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt_sub,
                                                input logic alt_sra);
        alu_op_e op;
        case (funct3)
            3'b000:  op = alt_sub ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt_sra ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purpose: purely combinational RV32I decode of one raw instruction into a dec_t bundle.
// Latency: zero cycles (no state).
// Backpressure: none; the enclosing stage owns all handshaking.
module decode_comb
    import decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    imm_fmt_e   fmt;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7_b5 = instr[30];

    always_comb begin
        dec     = '0;
        fmt     = IMM_NONE;
        dec.rd  = instr[11:7];
        dec.rs1 = instr[19:15];
        dec.rs2 = instr[24:20];
        dec.alu_op = ALU_ADD;

        // Opcode constants all end in 2'b11, so compressed encodings fall to default.
        case (opcode)
            OPC_OP: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = alu_from_funct3(funct3, funct7_b5, funct7_b5);
            end
            OPC_OP_IMM: begin
                fmt             = IMM_I;
                dec.reg_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
                dec.alu_op      = alu_from_funct3(funct3, 1'b0, funct7_b5);
            end
            OPC_LOAD: begin
                fmt             = IMM_I;
                dec.reg_write   = 1'b1;
                dec.mem_read    = 1'b1;
                dec.mem_to_reg  = 1'b1;
                dec.alu_src_imm = 1'b1;
            end
            OPC_STORE: begin
                fmt             = IMM_S;
                dec.mem_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
            end
            OPC_BRANCH: begin
                fmt        = IMM_B;
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt             = IMM_U;
                dec.reg_write   = 1'b1;
                dec.alu_src_imm = 1'b1;
            end
            OPC_JAL: begin
                fmt             = IMM_J;
                dec.reg_write   = 1'b1;
                dec.jump        = 1'b1;
                dec.alu_src_imm = 1'b1;
            end
            OPC_JALR: begin
                fmt             = IMM_I;
                dec.reg_write   = 1'b1;
                dec.jump        = 1'b1;
                dec.alu_src_imm = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase

        dec.imm = imm_extract(instr, fmt);
        if (dec.rd == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Purpose: decode stage with a two-entry (main + skid) buffer holding decoded bundles and pc.
// Latency: 1 cycle from input transfer to out_valid when empty; 1 instr/cycle sustained.
// Backpressure: in_ready = !skid_valid, registered, so out_ready never reaches in_ready combinationally.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4,
    parameter int REG_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [XLEN-1:0]     in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [REG_W-1:0]    rd,
    output logic [REG_W-1:0]    rs1,
    output logic [REG_W-1:0]    rs2,
    output logic [XLEN-1:0]     imm,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                branch,
    output logic                jump,
    output logic                alu_src_imm,
    output logic                illegal
);

    dec_t            dec;
    dec_t            main_dec;
    dec_t            skid_dec;
    logic [XLEN-1:0] main_pc;
    logic [XLEN-1:0] skid_pc;
    logic            main_vld;
    logic            skid_vld;
    logic            in_fire;
    logic            main_free;

    decode_comb u_decode (
        .instr (in_instr),
        .dec   (dec)
    );

    assign in_ready  = !skid_vld;
    assign in_fire   = in_valid && in_ready;
    // Main can take a new entry this edge if it is empty or being consumed.
    assign main_free = !main_vld || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_dec <= '0;
            skid_dec <= '0;
            main_pc  <= '0;
            skid_pc  <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (main_free) begin
            // Skid is always older than the input; in_fire cannot coincide with skid_vld.
            main_vld <= skid_vld || in_fire;
            skid_vld <= 1'b0;
            if (skid_vld) begin
                main_dec <= skid_dec;
                main_pc  <= skid_pc;
            end else if (in_fire) begin
                main_dec <= dec;
                main_pc  <= in_pc;
            end
        end else if (in_fire) begin
            skid_vld <= 1'b1;
            skid_dec <= dec;
            skid_pc  <= in_pc;
        end
    end

    assign out_valid   = main_vld;
    assign out_pc      = main_pc;
    assign rd          = REG_W'(main_dec.rd);
    assign rs1         = REG_W'(main_dec.rs1);
    assign rs2         = REG_W'(main_dec.rs2);
    assign imm         = XLEN'($signed(main_dec.imm));
    assign alu_op      = ALU_OP_W'(main_dec.alu_op);
    assign reg_write   = main_dec.reg_write;
    assign mem_read    = main_dec.mem_read;
    assign mem_write   = main_dec.mem_write;
    assign mem_to_reg  = main_dec.mem_to_reg;
    assign branch      = main_dec.branch;
    assign jump        = main_dec.jump;
    assign alu_src_imm = main_dec.alu_src_imm;
    assign illegal     = main_dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, decode table, buffering, flush, async reset, random stalls.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        reg_write, mem_read, mem_write, mem_to_reg, branch, jump, alu_src_imm, illegal;
    logic [7:0]  ctrl;
    logic [14:0] regs;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADD = 32'h002081B3;

    assign ctrl = {reg_write, mem_read, mem_write, mem_to_reg, branch, jump, alu_src_imm, illegal};
    assign regs = {rd, rs1, rs2};

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .ALU_OP_W(4), .REG_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .alu_op      (alu_op),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .branch      (branch),
        .jump        (jump),
        .alu_src_imm (alu_src_imm),
        .illegal     (illegal)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h40;
        step; step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
        checks++; if (regs !== 15'h0) begin errors++; $display("FAIL reset_regs got %h want 0", regs); end
        checks++; if (imm !== 32'h0) begin errors++; $display("FAIL reset_imm got %h want 0", imm); end
        checks++; if (alu_op !== 4'h0) begin errors++; $display("FAIL reset_alu_op got %h want 0", alu_op); end
        checks++; if (ctrl !== 8'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", ctrl); end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_decode_table;
        logic [31:0] ti [14];
        logic [14:0] tr [14];
        logic [31:0] tm [14];
        logic [3:0]  ta [14];
        logic [7:0]  tc [14];
        ti = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h002081B3, 32'h40208233, 32'h4030D293,
               32'h12345337, 32'hFFC12383, 32'h008000EF, 32'h00008067, 32'h00000013, 32'h00000000,
               32'h0000007F, 32'h002081B3};
        tr = '{{5'd1, 5'd0, 5'd31}, {5'd8, 5'd1, 5'd2}, {5'd29, 5'd0, 5'd0}, {5'd3, 5'd1, 5'd2},
               {5'd4, 5'd1, 5'd2}, {5'd5, 5'd1, 5'd3}, {5'd6, 5'd8, 5'd3}, {5'd7, 5'd2, 5'd28},
               {5'd1, 5'd0, 5'd8}, {5'd0, 5'd1, 5'd0}, {5'd0, 5'd0, 5'd0}, {5'd0, 5'd0, 5'd0},
               {5'd0, 5'd0, 5'd0}, {5'd3, 5'd1, 5'd2}};
        tm = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h00000403,
               32'h12345000, 32'hFFFFFFFC, 32'h00000008, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        ta = '{ALU_ADD, ALU_ADD, ALU_SUB, ALU_ADD, ALU_SUB, ALU_SRA, ALU_ADD, ALU_ADD,
               ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD, ALU_ADD};
        tc = '{8'h82, 8'h22, 8'h08, 8'h80, 8'h80, 8'h82, 8'h82, 8'hD2, 8'h86, 8'h06, 8'h02,
               8'h01, 8'h01, 8'h80};
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1; in_instr = ti[i]; in_pc = 32'h1000 + 32'(i * 4);
            step;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dec%0d_out_valid got %b want 1", i, out_valid); end
            checks++; if (out_pc !== 32'h1000 + 32'(i * 4)) begin errors++; $display("FAIL dec%0d_pc got %h want %h", i, out_pc, 32'h1000 + 32'(i * 4)); end
            checks++; if (regs !== tr[i]) begin errors++; $display("FAIL dec%0d_regs got %h want %h", i, regs, tr[i]); end
            checks++; if (imm !== tm[i]) begin errors++; $display("FAIL dec%0d_imm got %h want %h", i, imm, tm[i]); end
            checks++; if (alu_op !== ta[i]) begin errors++; $display("FAIL dec%0d_alu_op got %h want %h", i, alu_op, ta[i]); end
            checks++; if (ctrl !== tc[i]) begin errors++; $display("FAIL dec%0d_ctrl got %h want %h", i, ctrl, tc[i]); end
        end
        in_valid = 1'b0;
        step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dec_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        in_instr = I_ADD; out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'hA0;
        step;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hA0) begin errors++; $display("FAIL b2b_a_main got %b/%h want 1/a0", out_valid, out_pc); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %b want 1", in_ready); end
        in_pc = 32'hB0;
        step;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %b want 0", in_ready); end
        in_pc = 32'hC0;
        step;
        checks++; if (out_pc !== 32'hA0 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold got %h/%b want a0/0", out_pc, in_ready); end
        out_ready = 1'b1;
        step;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hB0) begin errors++; $display("FAIL b2b_b got %b/%h want 1/b0", out_valid, out_pc); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2 got %b want 1", in_ready); end
        step;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hC0) begin errors++; $display("FAIL b2b_c got %b/%h want 1/c0", out_valid, out_pc); end
        step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", out_valid); end
    endtask

    task automatic test_flush;
        in_instr = I_ADD; out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h200; step;
        in_pc = 32'h204; step;
        in_pc = 32'h208; flush = 1'b1; step;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_full_in_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak%0d got %b/%h want 0", i, out_valid, out_pc); end
        end
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h300; step;
        in_pc = 32'h304; flush = 1'b1; step;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_main_out_valid got %b want 0", out_valid); end
        step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_input_dropped got %b/%h want 0", out_valid, out_pc); end
        in_valid = 1'b1; in_pc = 32'h400; step;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h400) begin errors++; $display("FAIL flush_after got %b/%h want 1/400", out_valid, out_pc); end
        step;
    endtask

    task automatic test_rst_mid_stall;
        in_instr = I_ADD; out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h500; step;
        in_pc = 32'h504; step;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_async_in_ready got %b want 1", in_ready); end
        #3 rst = 1'b0;
        step;
        in_valid = 1'b1; in_pc = 32'h600; out_ready = 1'b1;
        step;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h600) begin errors++; $display("FAIL rst_first_out got %b/%h want 1/600", out_valid, out_pc); end
        step;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale got %b/%h want 0", out_valid, out_pc); end
    endtask

    task automatic test_random_stall;
        logic [31:0] exp_q [$];
        logic [31:0] want;
        int sent = 0;
        in_instr = I_ADD;
        for (int cyc = 0; cyc < 400 && (sent < 24 || exp_q.size() > 0); cyc++) begin
            in_valid  = (sent < 24) && ($urandom_range(0, 3) != 0);
            in_pc     = 32'h8000 + 32'(sent * 4);
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra got %h want none", out_pc);
                end else begin
                    want = exp_q.pop_front();
                    if (out_pc !== want) begin errors++; $display("FAIL rnd_order got %h want %h", out_pc, want); end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_pc);
                sent++;
            end
            step;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (sent != 24 || exp_q.size() != 0) begin
            errors++; $display("FAIL rnd_complete got sent=%0d left=%0d want 24/0", sent, exp_q.size());
        end
        step;
    endtask

    initial begin
        test_reset;
        test_decode_table;
        test_back_to_back;
        test_flush;
        test_rst_mid_stall;
        test_random_stall;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters SHALL be, one per line:
- XLEN, 32, datapath width; immediates are sign-extended to XLEN.
- ALU_OP_W, 4, alu_op width.
- REG_W, 5, register-index width.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  discard all buffered instructions.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- in_instr  in  32  raw RV32I instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  forwarded pc.
- rd, rs1, rs2  out  REG_W each  register indices.
- imm  out  XLEN  format-selected, sign-extended immediate.
- alu_op  out  ALU_OP_W  ALU operation code.
- reg_write, mem_read, mem_write, mem_to_reg, branch, jump, alu_src_imm  out  1 each  control selects.
- illegal  out  1  unsupported encoding.

Function
REQ-003 An input transfer SHALL occur on the clk edge where in_valid && in_ready; an output transfer SHALL occur on the edge where out_valid && out_ready.
REQ-004 The stage SHALL hold a two-entry buffer (main + skid); in_ready SHALL equal !skid_valid and be registered (no combinational path from out_ready).
REQ-005 Latency in_instr -> out_valid SHALL be exactly 1 cycle when the buffer is empty; sustained throughput SHALL be 1 instruction/cycle while out_ready=1.
REQ-006 Order SHALL be preserved; no instruction is dropped or duplicated under any out_ready pattern.
REQ-007 Accepting an input while main is valid and not draining SHALL write skid; when main drains, skid SHALL move to main on the same edge.
REQ-008 Decoding SHALL occur before the buffer; buffer entries hold the complete decoded bundle plus pc.
REQ-009 Supported opcodes SHALL be OP, OP-IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL and JALR; any other opcode, or instr[1:0] != 2'b11, SHALL set illegal=1 with all control selects 0.
REQ-010 imm SHALL follow the I, S, B, U or J format per opcode: B and J with bit 0 = 0, U with low 12 bits = 0, all sign-extended from instr[31] to XLEN; R-type imm = 0.
REQ-011 alu_op SHALL derive from funct3, and from funct7[5] for OP and for shifts; LOAD, STORE, AUIPC, JAL and JALR SHALL use ADD; BRANCH SHALL use SUB.
REQ-012 reg_write SHALL be 0 for STORE, BRANCH and illegal instructions and for rd=0.
REQ-013 flush SHALL clear main and skid valid on the next edge; an input offered in the flush cycle SHALL be discarded; flush SHALL take priority over every simultaneous transfer.

Reset
REQ-014 While rst=1, out_valid, skid valid and every output bundle field SHALL be 0 and in_ready SHALL be 1; inputs SHALL be ignored.
REQ-015 rst asserted mid-stall SHALL discard buffered entries immediately (asynchronously); the first transfer after release SHALL be a new input.

Structure
REQ-016 Opcode constants, ALU_OP encodings (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND) and immediate-format codes SHALL live in the shared opcode/alu definition files.
REQ-017 The combinational decoder SHALL be a sub-module decode_comb; decode_stage SHALL contain only the handshake buffer and the flush/reset logic.

Verification
REQ-018 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle: out_valid=1, rd=1, rs1=0, imm=0xFFFFFFFF, alu_op=ADD, reg_write=1, alu_src_imm=1.
REQ-019 0x0020A423 (sw x2,8(x1)) -> imm=8, rs1=1, rs2=2, mem_write=1, reg_write=0; 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, branch=1, alu_op=SUB.
REQ-020 out_ready=0 while three instructions A, B, C are offered back-to-back -> A and B are buffered, in_ready=0, C is held; out_ready=1 -> A, B, C are emitted in order on consecutive cycles.
REQ-021 0x00000000 and 0x0000007F -> illegal=1 with all control selects 0; a following valid instruction decodes normally.
REQ-022 flush with both entries full and in_valid=1 -> out_valid=0 next cycle, in_ready=1, and the offered input never appears at the output.
REQ-023 rst pulsed mid-stall -> out_valid=0 within the same cycle; after release, the first input emerges after 1-cycle latency.
